// File: rtl/md_dispatch_pkg.sv
// Shared encodings and op-class helpers for the multiply/divide issue controller.
package md_dispatch_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic is_start(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_write(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_MTHI, OP_MTLO: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_read(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_MFHI, OP_MFLO: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Anything outside the three classes (OP_NONE, unused codes) is swallowed on accept.
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return is_start(op) | is_write(op) | is_read(op);
  endfunction

endpackage

// File: rtl/md_hold_buf.sv
// One-entry holding buffer for an operation that arrived while the unit was busy.
module md_hold_buf
  import md_dispatch_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = OP_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           clear,
  input  logic [OPW-1:0] ld_op,
  input  logic [W-1:0]   ld_rs,
  input  logic [W-1:0]   ld_rt,
  output logic           buf_valid,
  output logic [OPW-1:0] buf_op,
  output logic [W-1:0]   buf_rs,
  output logic [W-1:0]   buf_rt
);

  logic           valid_r;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   rs_r;
  logic [W-1:0]   rt_r;

  // Entry storage; clear wins over load so a flush can never leave a stale op behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      op_r    <= OP_NONE;
      rs_r    <= {W{1'b0}};
      rt_r    <= {W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      op_r    <= OP_NONE;
    end else if (load) begin
      valid_r <= 1'b1;
      op_r    <= ld_op;
      rs_r    <= ld_rs;
      rt_r    <= ld_rt;
    end
  end

  assign buf_valid = valid_r;
  assign buf_op    = op_r;
  assign buf_rs    = rs_r;
  assign buf_rt    = rt_r;

endmodule

// File: rtl/md_dispatch.sv
// E-stage issue controller in front of the HI/LO multiply/divide unit.
// Optional stall counter enabled by defining MD_PERF_CNT_EN.
module md_dispatch
  import md_dispatch_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = OP_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [OPW-1:0] in_op,
  input  logic [W-1:0]   in_rs,
  input  logic [W-1:0]   in_rt,
  output logic           in_ready,
  input  logic           cancel,
  input  logic           md_busy,
  output logic           md_valid,
  output logic [OPW-1:0] md_op,
  output logic [W-1:0]   md_rs,
  output logic [W-1:0]   md_rt,
  output logic           md_cancel,
  input  logic [W-1:0]   rd_hi,
  input  logic [W-1:0]   rd_lo,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic [31:0]    perf_stall_cnt
);

  state_e         state_r;
  state_e         state_s;
  logic           in_ready_s;
  logic           accept_s;
  logic           launch_s;
  logic [OPW-1:0] launch_op_s;
  logic [W-1:0]   launch_rs_s;
  logic [W-1:0]   launch_rt_s;
  logic           buf_load_s;
  logic           buf_clear_s;
  logic           buf_valid_s;
  logic [OPW-1:0] buf_op_s;
  logic [W-1:0]   buf_rs_s;
  logic [W-1:0]   buf_rt_s;
  logic           rd_fire_s;

  logic           md_valid_r;
  logic [OPW-1:0] md_op_r;
  logic [W-1:0]   md_rs_r;
  logic [W-1:0]   md_rt_r;
  logic           res_valid_r;
  logic [W-1:0]   res_data_r;

  assign in_ready_s = (state_r != ST_HOLD) && !cancel;
  assign accept_s   = in_valid && in_ready_s;

  md_hold_buf #(
    .W   (W),
    .OPW (OPW)
  ) u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .ld_op     (in_op),
    .ld_rs     (in_rs),
    .ld_rt     (in_rt),
    .buf_valid (buf_valid_s),
    .buf_op    (buf_op_s),
    .buf_rs    (buf_rs_s),
    .buf_rt    (buf_rt_s)
  );

  // Next-state and launch selection; cancel overrides every other transition.
  always_comb begin
    state_s     = state_r;
    launch_s    = 1'b0;
    launch_op_s = in_op;
    launch_rs_s = in_rs;
    launch_rt_s = in_rt;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    if (cancel) begin
      state_s     = ST_IDLE;
      buf_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_md_op(in_op)) begin
            if (md_busy) begin
              state_s    = ST_HOLD;
              buf_load_s = 1'b1;
            end else begin
              state_s  = ST_ISSUE;
              launch_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        // The unit reports busy for its own start, so a follow-on op always parks first.
        ST_ISSUE: begin
          if (accept_s && is_md_op(in_op)) begin
            state_s    = ST_HOLD;
            buf_load_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!buf_valid_s) begin
            state_s = ST_IDLE;
          end else if (!md_busy) begin
            state_s     = ST_ISSUE;
            launch_s    = 1'b1;
            launch_op_s = buf_op_s;
            launch_rs_s = buf_rs_s;
            launch_rt_s = buf_rt_s;
            buf_clear_s = 1'b1;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          buf_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State register and registered launch port toward the unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      md_valid_r <= 1'b0;
      md_op_r    <= OP_NONE;
      md_rs_r    <= {W{1'b0}};
      md_rt_r    <= {W{1'b0}};
    end else begin
      state_r    <= state_s;
      md_valid_r <= launch_s;
      md_op_r    <= launch_s ? launch_op_s : OP_NONE;
      if (launch_s) begin
        md_rs_r <= launch_rs_s;
        md_rt_r <= launch_rt_s;
      end
    end
  end

  assign rd_fire_s = (state_r == ST_ISSUE) && is_read(md_op_r) && !cancel;

  // mfhi/mflo capture: HI/LO are sampled at the end of the read's launch cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {W{1'b0}};
    end else begin
      res_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        res_data_r <= (md_op_r == OP_MFHI) ? rd_hi : rd_lo;
      end
    end
  end

`ifdef MD_PERF_CNT_EN
  logic [31:0] perf_cnt_r;

  // Counts pipeline stall cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_r <= 32'd0;
    end else if (in_valid && !in_ready_s && !cancel) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  assign in_ready  = in_ready_s;
  assign md_cancel = cancel && (state_r == ST_ISSUE);
  assign md_valid  = md_valid_r;
  assign md_op     = md_op_r;
  assign md_rs     = md_rs_r;
  assign md_rt     = md_rt_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;

endmodule

// File: tb/tb_md_dispatch.sv
// Scoreboard bench for md_dispatch with a behavioural HI/LO unit attached.
module tb_md_dispatch;
  import md_dispatch_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cncl;
  } launch_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_rs, in_rt;
  logic        in_ready;
  logic        cancel;
  logic        md_busy;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] md_rs, md_rt;
  logic        md_cancel;
  logic [31:0] rd_hi, rd_lo;
  logic        res_valid;
  logic [31:0] res_data;
  logic [31:0] perf_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  launch_t     exp_launch_q[$];
  logic [31:0] exp_res_q[$];
  launch_t     mon_e;
  logic [31:0] mon_r;

  logic [31:0] u_hi, u_lo;
  logic [63:0] u_p;
  logic [3:0]  u_cnt;

  always #5 clk = ~clk;

  md_dispatch dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_rs          (in_rs),
    .in_rt          (in_rt),
    .in_ready       (in_ready),
    .cancel         (cancel),
    .md_busy        (md_busy),
    .md_valid       (md_valid),
    .md_op          (md_op),
    .md_rs          (md_rs),
    .md_rt          (md_rt),
    .md_cancel      (md_cancel),
    .rd_hi          (rd_hi),
    .rd_lo          (rd_lo),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural HI/LO unit: busy on its start cycle and while counting down.
  assign md_busy = (md_valid && is_start(md_op)) || (u_cnt != 4'd0);
  assign rd_hi   = u_hi;
  assign rd_lo   = u_lo;

  always @(posedge clk) begin
    if (reset) begin
      u_cnt <= 4'd0;
      u_hi  <= 32'd0;
      u_lo  <= 32'd0;
      u_p   <= 64'd0;
    end else if (md_valid && !md_cancel) begin
      case (md_op)
        OP_MULT: begin
          u_p   <= {{32{md_rs[31]}}, md_rs} * {{32{md_rt[31]}}, md_rt};
          u_cnt <= 4'(MUL_LAT);
        end
        OP_MULTU: begin
          u_p   <= {32'd0, md_rs} * {32'd0, md_rt};
          u_cnt <= 4'(MUL_LAT);
        end
        OP_DIV: begin
          u_p   <= (md_rt == 32'd0) ? 64'd0 :
                   {32'($signed(md_rs) % $signed(md_rt)), 32'($signed(md_rs) / $signed(md_rt))};
          u_cnt <= 4'(DIV_LAT);
        end
        OP_DIVU: begin
          u_p   <= (md_rt == 32'd0) ? 64'd0 : {md_rs % md_rt, md_rs / md_rt};
          u_cnt <= 4'(DIV_LAT);
        end
        OP_MTHI: u_hi <= md_rs;
        OP_MTLO: u_lo <= md_rs;
        default: ;
      endcase
    end else if (u_cnt != 4'd0) begin
      u_cnt <= u_cnt - 4'd1;
      if (u_cnt == 4'd1) begin
        u_hi <= u_p[63:32];
        u_lo <= u_p[31:0];
      end
    end
  end

  // Scoreboard side: every launch and every result must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (md_valid) begin
        if (exp_launch_q.size() == 0) begin
          check_eq("launch_unexpected", 64'(md_op), 64'(OP_NONE));
        end else begin
          mon_e = exp_launch_q.pop_front();
          check_eq("launch_op", 64'(md_op), 64'(mon_e.op));
          check_eq("launch_rs", 64'(md_rs), 64'(mon_e.rs));
          check_eq("launch_rt", 64'(md_rt), 64'(mon_e.rt));
          check_eq("launch_cancel", 64'(md_cancel), 64'(mon_e.cncl));
        end
      end else begin
        check_eq("md_op_idle", 64'(md_op), 64'(OP_NONE));
        check_eq("md_cancel_idle", 64'(md_cancel), 64'd0);
      end
      if (res_valid) begin
        if (exp_res_q.size() == 0) begin
          check_eq("res_unexpected", 64'(res_valid), 64'd0);
        end else begin
          mon_r = exp_res_q.pop_front();
          check_eq("res_data", 64'(res_data), 64'(mon_r));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call right after a rising edge; returns just after the edge that accepted the op.
  task automatic issue_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit launch_exp, input bit cncl_exp);
    launch_t e;
    bit      acc;
    int      waits;
    acc   = 1'b0;
    waits = 0;
    if (launch_exp) begin
      e.op   = op;
      e.rs   = rs;
      e.rt   = rt;
      e.cncl = cncl_exp;
      exp_launch_q.push_back(e);
    end
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready && !cancel;
      @(posedge clk);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 100) begin
          check_eq("accept_timeout", 64'd1, 64'd0);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_op    = OP_NONE;
    in_rs    = 32'd0;
    in_rt    = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_op    = OP_NONE;
    in_rs    = 32'd0;
    in_rt    = 32'd0;
    cancel   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_md_valid", 64'(md_valid), 64'd0);
    check_eq("rst_md_op", 64'(md_op), 64'(OP_NONE));
    check_eq("rst_md_rs", 64'(md_rs), 64'd0);
    check_eq("rst_md_rt", 64'(md_rt), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_res_data", 64'(res_data), 64'd0);
    check_eq("rst_perf", 64'(perf_stall_cnt), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // MTHI in idle launches the next cycle
    step();
    issue_op(OP_MTHI, 32'h1234, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("mthi_md_valid", 64'(md_valid), 64'd1);
    check_eq("mthi_md_op", 64'(md_op), 64'(OP_MTHI));
    check_eq("mthi_md_rs", 64'(md_rs), 64'h1234);
    check_eq("mthi_in_ready", 64'(in_ready), 64'd1);
    step();

    // MULT then MFLO back to back: MFLO parks until the unit frees up
    issue_op(OP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b1, 1'b0);
    exp_res_q.push_back(32'hFFFF_FFFA);
    issue_op(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
    guard = 0;
    @(negedge clk);
    while (md_busy && guard < 50) begin
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      guard++;
      @(negedge clk);
    end
    check_eq("hold_busy_drop", 64'(md_busy), 64'd0);
    @(negedge clk);
    check_eq("mflo_launch_valid", 64'(md_valid), 64'd1);
    check_eq("mflo_launch_op", 64'(md_op), 64'(OP_MFLO));
    repeat (3) step();

    // DIV cancelled in its launch cycle; the following op sees no busy wait
    issue_op(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b1);
    cancel = 1'b1;
    @(negedge clk);
    check_eq("div_md_cancel", 64'(md_cancel), 64'd1);
    check_eq("div_cancel_in_ready", 64'(in_ready), 64'd0);
    step();
    cancel = 1'b0;
    @(negedge clk);
    check_eq("post_cancel_busy", 64'(md_busy), 64'd0);
    check_eq("post_cancel_in_ready", 64'(in_ready), 64'd1);
    step();
    issue_op(OP_MTLO, 32'h55, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("mtlo_latency", 64'(md_valid), 64'd1);
    repeat (2) step();

    // MFHI parked behind MULTU, then flushed: no result ever appears
    issue_op(OP_MULTU, 32'd5, 32'd7, 1'b1, 1'b0);
    issue_op(OP_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    cancel = 1'b1;
    @(negedge clk);
    check_eq("hold_cancel_md_cancel", 64'(md_cancel), 64'd0);
    step();
    cancel = 1'b0;
    @(negedge clk);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_md_valid", 64'(md_valid), 64'd0);
    repeat (12) step();
    check_eq("res_data_held", 64'(res_data), 64'hFFFF_FFFA);

    // Reset while a DIVU sits in the buffer
    issue_op(OP_MULT, 32'd2, 32'd3, 1'b1, 1'b0);
    issue_op(OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_md_valid", 64'(md_valid), 64'd0);
    check_eq("mid_rst_md_op", 64'(md_op), 64'(OP_NONE));
    check_eq("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("mid_rst_perf", 64'(perf_stall_cnt), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) step();
    check_eq("mid_rst_no_launch", 64'(md_valid), 64'd0);

    // OP_NONE is swallowed
    issue_op(OP_NONE, 32'd1, 32'd2, 1'b0, 1'b0);
    repeat (3) step();

    // Stall counting: MFLO waits MUL_LAT busy cycles plus the dispatch cycle
    issue_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    exp_res_q.push_back(32'd1);
    issue_op(OP_MFHI, 32'd0, 32'd0, 1'b1, 1'b0);
    exp_res_q.push_back(32'd0);
    issue_op(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (6) step();
`ifdef MD_PERF_CNT_EN
    check_eq("perf_stall_cnt", 64'(perf_stall_cnt), 64'(MUL_LAT + 1));
`else
    check_eq("perf_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif

    check_eq("launch_q_drained", 64'(exp_launch_q.size()), 64'd0);
    check_eq("res_q_drained", 64'(exp_res_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_dispatch.md
Name: md_dispatch

Overview:
- E-stage issue controller sitting directly upstream of the multiply/divide unit (HI/LO owner).
- Accepts mult/div, mthi/mtlo and mfhi/mflo operations from the pipeline and launches each to the unit as a one-cycle registered request, only when the unit is idle.
- Buffers one operation while the unit is busy and backpressures the pipeline through in_ready.
- Returns mfhi/mflo results and forwards exception flushes as a unit-side cancel.

Parameters:
- W, 32, datapath width of operands and results.
- OPW, 4, width of the operation code.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pipeline presents an MD operation.
- in_op  input  OPW  operation code (package encoding).
- in_rs  input  W  rs operand.
- in_rt  input  W  rt operand.
- in_ready  output  1  operation accepted this cycle if in_valid; the pipeline stalls on in_valid && !in_ready.
- cancel  input  1  exception flush from M stage.
- md_busy  input  1  unit busy (start | counter != 0).
- md_valid  output  1  registered one-cycle launch strobe to the unit.
- md_op  output  OPW  launched operation.
- md_rs  output  W  launched rs.
- md_rt  output  W  launched rt.
- md_cancel  output  1  kills the launch in flight.
- rd_hi  input  W  unit HI register.
- rd_lo  input  W  unit LO register.
- res_valid  output  1  one-cycle pulse; mfhi/mflo result available.
- res_data  output  W  mfhi/mflo result.
- perf_stall_cnt  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset: state IDLE, md_valid=0, md_op=OP_NONE, md_rs=md_rt=0, res_valid=0, res_data=0, perf_stall_cnt=0, buffer empty.
- Op classes:
  - START: MULT, MULTU, DIV, DIVU.
  - WRITE: MTHI, MTLO.
  - READ: MFHI, MFLO.
  - OP_NONE with in_valid=1 is accepted and discarded.
- in_ready = (state != HOLD) && !cancel.
- accept = in_valid && in_ready.
- States:
  - IDLE:
    - accept && !md_busy -> ISSUE; md_* loaded from in_*.
    - accept && md_busy -> HOLD; op captured in buffer.
    - otherwise stay in IDLE.
  - ISSUE: md_valid=1 for exactly this cycle.
    - accept -> HOLD. The buffer is always used, even for WRITE/READ, so a back-to-back op has a 1-cycle bubble.
    - otherwise -> IDLE.
  - HOLD:
    - !md_busy && !cancel -> ISSUE; md_* loaded from buffer.
    - else stay in HOLD.
- md_valid/md_op/md_rs/md_rt are registered. Launch latency is 1 cycle after accept when the unit is idle.
- md_op returns to OP_NONE whenever md_valid=0.
- READ in ISSUE:
  - At the end of the cycle, res_data <= (MFHI ? rd_hi : rd_lo).
  - res_valid=1 in the next cycle only.
  - res_data holds its value until the next READ.
- cancel:
  - md_cancel = cancel && state==ISSUE; the unit ignores that launch.
  - Buffer is cleared; next state is IDLE; in_valid in the same cycle is not accepted.
  - A READ cancelled in ISSUE produces no res_valid.
  - A START already running in the unit (launched in an earlier cycle) is not affected; later ops still wait on md_busy.
- Simultaneous events:
  - cancel outranks accept and dispatch.
  - reset outranks cancel.
  - Reset mid-operation returns to IDLE in one cycle.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- With it defined:
  - perf_stall_cnt increments by 1 on every cycle with in_valid && !in_ready && !cancel.
  - Wraps 0xFFFFFFFF -> 0; cleared by reset.
- Without it: perf_stall_cnt is constant 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - OP_* encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - is_start / is_write / is_read helpers.
  - FSM state encoding: IDLE=0, ISSUE=1, HOLD=2.
- One sub-module: md_hold_buf, a one-entry buffer with load/clear/valid for op, rs, rt.

Test Plan:
- Reset, then MTHI rs=0x1234 accepted in idle -> md_valid in the next cycle with md_op=MTHI, md_rs=0x1234; in_ready=1 throughout.
- MULT rs=3, rt=0xFFFFFFFE, then MFLO the next cycle -> MFLO held, in_ready=0 while md_busy=1. md_valid(MFLO) comes 1 cycle after the first md_busy=0 cycle; then res_valid with res_data=0xFFFFFFFA.
- DIV issued; cancel asserted during its ISSUE cycle -> md_cancel=1 that cycle, state IDLE, no busy wait, next op launches 1 cycle after accept.
- Unit busy, MFHI buffered, cancel pulse -> buffer cleared, no res_valid ever, in_ready=1 on the following cycle.
- Reset asserted in HOLD with buffered DIVU -> next cycle md_valid=0, state IDLE, res_valid=0, perf_stall_cnt=0.
- MD_PERF_CNT_EN defined, MULT followed by MFHI -> perf_stall_cnt equals the number of in_valid && !in_ready cycles (unit latency dependent, checked against a scoreboard). Undefined -> stays 0.
